// File: rtl/lfsr_note_gen.sv
// rtl/lfsr_note_gen.sv - LFSR-based random draw generator with optional no-repeat rule
//
// Purpose:
//   Free-running Fibonacci LFSR, advanced only while a draw is in progress.
//   A draw shifts the LFSR DECIM times, then takes the top OUT_W bits as the
//   candidate. With NO_REPEAT set, a candidate equal to the previous draw is
//   retried up to three times before falling back to candidate+1.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   seed_load  in   load seed into the LFSR, abort any draw
//   seed       in   LFSR_W seed value (zero selects SEED)
//   req        in   draw request, honoured only in IDLE
//   rnd        out  OUT_W last completed draw (shows the new value in the valid cycle)
//   valid      out  one-cycle pulse, rnd updated this cycle
//   busy       out  high while a draw is in progress

module lfsr_note_gen #(
   parameter int                LFSR_W    = 16,
   parameter int                OUT_W     = 4,
   parameter logic [LFSR_W-1:0] TAPS      = 16'hD008,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                DECIM     = LFSR_W,
   parameter int                NO_REPEAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              req,
   output logic [OUT_W-1:0]  rnd,
   output logic              valid,
   output logic              busy
);

   localparam int              CNT_W    = $clog2(DECIM + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              fsm;
   state_t              fsm_nxt;
   logic [LFSR_W-1:0]   lfsr;
   logic [LFSR_W-1:0]   lfsr_step;
   logic [LFSR_W-1:0]   seed_val;
   logic                fb;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          retry;
   logic [OUT_W-1:0]    rnd_q;
   logic [OUT_W-1:0]    cand;
   logic [OUT_W-1:0]    rnd_new;
   logic                last_shift;
   logic                repeat_hit;
   logic                retry_go;

   // Datapath helpers
   assign fb         = ^(lfsr & TAPS);
   assign lfsr_step  = {lfsr[LFSR_W-2:0], fb};
   // A zero seed would lock the LFSR, so it is replaced by SEED.
   assign seed_val   = (seed == '0) ? SEED : seed;
   assign cand       = lfsr[LFSR_W-1 -: OUT_W];
   assign last_shift = (cnt == CNT_LAST);
   assign repeat_hit = (NO_REPEAT != 0) && (cand == rnd_q);
   // Retry is taken only while budget remains; on the fourth hit we fall back.
   assign retry_go   = repeat_hit && (retry != 2'd3);
   assign rnd_new    = repeat_hit ? cand + OUT_W'(1) : cand;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      fsm_nxt = fsm;
      if (seed_load) begin
         fsm_nxt = IDLE;
      end else begin
         case (fsm)
            IDLE:    if (req) fsm_nxt = SHIFT;
            SHIFT:   if (last_shift) fsm_nxt = DONE;
            DONE:    fsm_nxt = retry_go ? SHIFT : IDLE;
            default: fsm_nxt = IDLE;
         endcase
      end
   end

   // Outputs; valid is suppressed when a seed load aborts the DONE cycle.
   always_comb begin
      busy  = (fsm != IDLE);
      valid = (fsm == DONE) && !seed_load && !retry_go;
      rnd   = valid ? rnd_new : rnd_q;
   end

   // LFSR, counters and held result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr  <= SEED;
         cnt   <= '0;
         retry <= 2'd0;
         rnd_q <= '0;
      end else if (seed_load) begin
         lfsr  <= seed_val;
         cnt   <= '0;
         retry <= 2'd0;
      end else begin
         case (fsm)
            IDLE: begin
               if (req) begin
                  cnt   <= '0;
                  retry <= 2'd0;
               end
            end
            SHIFT: begin
               lfsr <= lfsr_step;
               cnt  <= last_shift ? '0 : cnt + CNT_W'(1);
            end
            DONE: begin
               if (valid) begin
                  rnd_q <= rnd_new;
               end else if (retry_go) begin
                  retry <= retry + 2'd1;
                  cnt   <= '0;
               end
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_note_gen.sv
// tb/tb_lfsr_note_gen.sv - self-checking bench for lfsr_note_gen
module tb_lfsr_note_gen;

   localparam logic [15:0] TAPS_M  = 16'hD008;
   localparam logic [15:0] SEED_M  = 16'hACE1;
   localparam int M_DECIM [0:2] = '{16, 1, 16};
   localparam int M_OUTW  [0:2] = '{4, 4, 1};
   localparam int M_NOREP [0:2] = '{0, 0, 1};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_v       [0:2];
   logic        seed_load_v [0:2];
   logic [15:0] seed_v      [0:2];

   logic [3:0]  rnd_0, rnd_1;
   logic [0:0]  rnd_2;
   logic        valid_0, valid_1, valid_2;
   logic        busy_0, busy_1, busy_2;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] m_state [0:2];
   int          m_prev  [0:2];

   typedef struct {
      logic [15:0] seed;
      int          exp_rnd;
   } vec_t;
   vec_t tbl [0:5];

   always #5 clk = ~clk;

   lfsr_note_gen u_def (
      .clk(clk), .rst(rst), .seed_load(seed_load_v[0]), .seed(seed_v[0]),
      .req(req_v[0]), .rnd(rnd_0), .valid(valid_0), .busy(busy_0)
   );

   lfsr_note_gen #(.DECIM(1)) u_d1 (
      .clk(clk), .rst(rst), .seed_load(seed_load_v[1]), .seed(seed_v[1]),
      .req(req_v[1]), .rnd(rnd_1), .valid(valid_1), .busy(busy_1)
   );

   lfsr_note_gen #(.OUT_W(1), .NO_REPEAT(1)) u_nr (
      .clk(clk), .rst(rst), .seed_load(seed_load_v[2]), .seed(seed_v[2]),
      .req(req_v[2]), .rnd(rnd_2), .valid(valid_2), .busy(busy_2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int get_valid(input int sel);
      case (sel)
         0:       return int'(valid_0);
         1:       return int'(valid_1);
         default: return int'(valid_2);
      endcase
   endfunction

   function automatic int get_rnd(input int sel);
      case (sel)
         0:       return int'(rnd_0);
         1:       return int'(rnd_1);
         default: return int'(rnd_2);
      endcase
   endfunction

   function automatic int get_busy(input int sel);
      case (sel)
         0:       return int'(busy_0);
         1:       return int'(busy_1);
         default: return int'(busy_2);
      endcase
   endfunction

   // Reference model: one draw as a transaction.
   function automatic logic [15:0] lstep(input logic [15:0] s);
      int p;
      p = $countones(s & TAPS_M) % 2;
      return {s[14:0], (p == 1)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_state[i] = SEED_M;
         m_prev[i]  = 0;
      end
   endtask

   task automatic model_draw(input int sel, output int lat, output int val);
      logic [15:0] s;
      int cand;
      bit done;
      s = m_state[sel]; done = 0; lat = -1; val = -1;
      for (int k = 0; k < 4; k++) begin
         if (!done) begin
            for (int i = 0; i < M_DECIM[sel]; i++) s = lstep(s);
            cand = int'(s) >> (16 - M_OUTW[sel]);
            if (M_NOREP[sel] == 0 || cand != m_prev[sel]) begin
               val = cand; lat = (M_DECIM[sel] + 1) * (k + 1); done = 1;
            end else if (k == 3) begin
               val = (cand + 1) % (1 << M_OUTW[sel]); lat = (M_DECIM[sel] + 1) * 4; done = 1;
            end
         end
      end
      m_state[sel] = s;
      m_prev[sel]  = val;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Issues one req, optionally pulses req again at given cycles, waits for valid.
   task automatic draw(input int sel, input int p1, input int p2, input int p3,
                       output int lat, output int val);
      bit found;
      found = 0; lat = 0; val = -1;
      req_v[sel] = 1'b1;
      while (!found && lat < 400) begin
         tick(); lat++;
         req_v[sel] = (lat == p1 || lat == p2 || lat == p3);
         if (get_valid(sel) != 0) begin
            found = 1; val = get_rnd(sel);
         end
      end
      req_v[sel] = 1'b0;
      if (!found) check("draw_timeout", 0, 1);
      tick();
   endtask

   task automatic draw_and_check(input string name, input int sel,
                                 input int p1, input int p2, input int p3);
      int lat, val, mlat, mval;
      draw(sel, p1, p2, p3, lat, val);
      model_draw(sel, mlat, mval);
      check({name, "_lat"}, lat, mlat);
      check({name, "_rnd"}, val, mval);
   endtask

   task automatic load_seed(input int sel, input logic [15:0] s);
      seed_v[sel] = s;
      seed_load_v[sel] = 1'b1;
      tick();
      seed_load_v[sel] = 1'b0;
      check("seed_busy", get_busy(sel), 0);
      m_state[sel] = (s == 16'h0) ? SEED_M : s;
   endtask

   task automatic count_valids(input int sel, input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (get_valid(sel) != 0) n++;
      end
   endtask

   task automatic run_continuous();
      int cyc, last, n, lowcnt, lat, val, nseen;
      bit seen [0:15];
      cyc = 0; last = 0; n = 0; lowcnt = 0; nseen = 0;
      for (int i = 0; i < 16; i++) seen[i] = 0;
      req_v[0] = 1'b1;
      while (n < 1000 && cyc < 1000 * 18 + 200) begin
         tick(); cyc++;
         if (valid_0) begin
            model_draw(0, lat, val);
            check("cont_rnd", int'(rnd_0), val);
            if (n == 0) begin
               check("cont_first_lat", cyc, lat);
            end else begin
               check("cont_period", cyc - last, 18);
               check("cont_busy_low", lowcnt, 1);
            end
            seen[rnd_0] = 1;
            last = cyc; lowcnt = 0; n++;
            if (n == 1000) req_v[0] = 1'b0;
         end else if (!busy_0) begin
            lowcnt++;
         end
      end
      req_v[0] = 1'b0;
      check("cont_draws", n, 1000);
      for (int i = 0; i < 16; i++) if (seen[i]) nseen++;
      check("cont_all_values", nseen, 16);
      tick(); tick();
   endtask

   initial begin
      int lat, val, mlat, mval, prev, n, r;
      for (int i = 0; i < 3; i++) begin
         req_v[i] = 1'b0; seed_load_v[i] = 1'b0; seed_v[i] = 16'h0;
      end
      tbl[0] = '{16'hACE1, 5};
      tbl[1] = '{16'h0000, 5};
      tbl[2] = '{16'h8000, 0};
      tbl[3] = '{16'h7FFF, 15};
      tbl[4] = '{16'h1234, 2};
      tbl[5] = '{16'h4800, 9};
      model_reset();

      // Reset and idle
      repeat (2) tick();
      rst = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 3; i++) begin
         check("reset_rnd", get_rnd(i), 0);
         check("reset_valid", get_valid(i), 0);
         check("reset_busy", get_busy(i), 0);
      end

      // DECIM=1 from the reset seed: ACE1 -> 59C3 gives 5, then 59C3 -> ... gives B
      draw(1, -1, -1, -1, lat, val);
      model_draw(1, mlat, mval);
      check("d1_first_lat", lat, 2);
      check("d1_first_rnd", val, 5);
      draw(1, -1, -1, -1, lat, val);
      model_draw(1, mlat, mval);
      check("d1_second_rnd", val, 11);

      // Seed table on the DECIM=1 instance
      for (int i = 0; i < 6; i++) begin
         load_seed(1, tbl[i].seed);
         draw(1, -1, -1, -1, lat, val);
         model_draw(1, mlat, mval);
         check("tbl_lat", lat, 2);
         check("tbl_rnd", val, tbl[i].exp_rnd);
      end

      // Continuous request on defaults
      run_continuous();

      // No-repeat, single-bit output
      prev = m_prev[2];
      for (int i = 0; i < 200; i++) begin
         draw(2, -1, -1, -1, lat, val);
         model_draw(2, mlat, mval);
         check("nr_alternate", (val != prev) ? 1 : 0, 1);
         check("nr_lat", lat, mlat);
         check("nr_lat_multiple", ((lat % 17 == 0) && lat >= 17 && lat <= 68) ? 1 : 0, 1);
         check("nr_rnd", val, mval);
         prev = val;
      end

      // Zero seed loaded mid-SHIFT
      req_v[0] = 1'b1; tick(); req_v[0] = 1'b0;
      repeat (4) tick();
      r = int'(rnd_0);
      seed_v[0] = 16'h0; seed_load_v[0] = 1'b1;
      tick();
      seed_load_v[0] = 1'b0;
      m_state[0] = SEED_M;
      check("abort_busy", int'(busy_0), 0);
      check("abort_valid", int'(valid_0), 0);
      check("abort_rnd", int'(rnd_0), r);
      count_valids(0, 30, n);
      check("abort_no_valid", n, 0);
      draw_and_check("after_abort", 0, -1, -1, -1);

      // seed_load and req together
      seed_v[0] = 16'h1357; seed_load_v[0] = 1'b1; req_v[0] = 1'b1;
      tick();
      seed_load_v[0] = 1'b0; req_v[0] = 1'b0;
      m_state[0] = 16'h1357;
      check("sl_req_busy", int'(busy_0), 0);
      tick();
      check("sl_req_not_queued", int'(busy_0), 0);
      draw_and_check("after_sl_req", 0, -1, -1, -1);

      // req pulses while busy are ignored
      draw_and_check("busy_req", 0, 3, 9, 16);
      count_valids(0, 25, n);
      check("busy_req_no_extra", n, 0);

      // Asynchronous reset five cycles into SHIFT
      req_v[0] = 1'b1; tick(); req_v[0] = 1'b0;
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_rnd", int'(rnd_0), 0);
      check("arst_busy", int'(busy_0), 0);
      check("arst_valid", int'(valid_0), 0);
      tick();
      rst = 1'b0;
      model_reset();
      count_valids(0, 40, n);
      check("arst_no_valid", n, 0);
      draw_and_check("after_arst", 0, -1, -1, -1);

      // Randomized mix of seed loads and draws on all instances
      for (int it = 0; it < 120; it++) begin
         int sel, op;
         sel = $urandom_range(0, 2);
         op  = $urandom_range(0, 4);
         if (op == 0) begin
            load_seed(sel, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
         end else begin
            draw_and_check("rand", sel,
                           ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 20)),
                           ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 20)),
                           -1);
         end
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
